// File: rtl/sequenciador_rpn.sv
// Step sequencer for the 8-bit RPN ALU: debounces Enter/Limpar and walks A -> B -> Op/Carry -> Result,
// capturing switch values into the ALU operand registers and latching the ALU result for display.

module sequenciador_rpn_debounce #(
  parameter int DEBOUNCE_CICLOS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulso
);
  localparam int CW = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          estavel_q, estavel_d;
  logic          estavel_atr_q, estavel_atr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with the accepted level.
  always_comb begin
    s1_d          = raw;
    s2_d          = s1_q;
    estavel_d     = estavel_q;
    estavel_atr_d = estavel_q;
    cnt_d         = cnt_q;
    if (s2_q == estavel_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      estavel_d = s2_q;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      estavel_q     <= 1'b0;
      estavel_atr_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      estavel_q     <= estavel_d;
      estavel_atr_q <= estavel_atr_d;
      cnt_q         <= cnt_d;
    end
  end

  assign pulso = estavel_q & ~estavel_atr_q;
endmodule

module sequenciador_rpn #(
  parameter int LARGURA         = 8,
  parameter int DEBOUNCE_CICLOS = 16,
  parameter int ENCADEAR        = 1
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Enter,
  input  logic               Limpar,
  input  logic [LARGURA-1:0] Chaves,
  input  logic [LARGURA-1:0] Resultado_ula,
  input  logic               Carry_ula,
  output logic [LARGURA-1:0] OperandoA,
  output logic [LARGURA-1:0] OperandoB,
  output logic [2:0]         Operacao,
  output logic               CarryIn,
  output logic [1:0]         Passo,
  output logic [LARGURA-1:0] Resultado,
  output logic               CarryOut,
  output logic               Resultado_valido,
  output logic               Enter_pulso
);
  typedef enum logic [1:0] {
    PASSO_A   = 2'b00,
    PASSO_B   = 2'b01,
    PASSO_OP  = 2'b10,
    PASSO_RES = 2'b11
  } passo_t;

  logic enter_pulso;
  logic limpar_pulso;

  sequenciador_rpn_debounce #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_db_enter (
    .clk(Clock), .rst_n(Reset_n), .raw(Enter), .pulso(enter_pulso)
  );

  sequenciador_rpn_debounce #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_db_limpar (
    .clk(Clock), .rst_n(Reset_n), .raw(Limpar), .pulso(limpar_pulso)
  );

  passo_t               passo_q, passo_d;
  logic [LARGURA-1:0]   op_a_q, op_a_d;
  logic [LARGURA-1:0]   op_b_q, op_b_d;
  logic [2:0]           opcode_q, opcode_d;
  logic                 cin_q, cin_d;
  logic [LARGURA-1:0]   res_q, res_d;
  logic                 cout_q, cout_d;
  logic                 valido_q, valido_d;

  // Limpar outranks a coincident Enter strobe.
  always_comb begin
    passo_d  = passo_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    opcode_d = opcode_q;
    cin_d    = cin_q;
    res_d    = res_q;
    cout_d   = cout_q;
    valido_d = valido_q;
    if (limpar_pulso) begin
      passo_d  = PASSO_A;
      op_a_d   = '0;
      op_b_d   = '0;
      opcode_d = '0;
      cin_d    = 1'b0;
      res_d    = '0;
      cout_d   = 1'b0;
      valido_d = 1'b0;
    end else if (enter_pulso) begin
      case (passo_q)
        PASSO_A: begin
          op_a_d  = Chaves;
          passo_d = PASSO_B;
        end
        PASSO_B: begin
          op_b_d  = Chaves;
          passo_d = PASSO_OP;
        end
        PASSO_OP: begin
          opcode_d = Chaves[2:0];
          cin_d    = Chaves[3];
          passo_d  = PASSO_RES;
        end
        PASSO_RES: begin
          res_d    = Resultado_ula;
          cout_d   = Carry_ula;
          valido_d = 1'b1;
          if (ENCADEAR != 0) begin
            op_a_d  = Resultado_ula;
            passo_d = PASSO_B;
          end else begin
            passo_d = PASSO_A;
          end
        end
        default: passo_d = PASSO_A;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      passo_q  <= PASSO_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      opcode_q <= '0;
      cin_q    <= 1'b0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      valido_q <= 1'b0;
    end else begin
      passo_q  <= passo_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      opcode_q <= opcode_d;
      cin_q    <= cin_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
      valido_q <= valido_d;
    end
  end

  assign OperandoA        = op_a_q;
  assign OperandoB        = op_b_q;
  assign Operacao         = opcode_q;
  assign CarryIn          = cin_q;
  assign Passo            = passo_q;
  assign Resultado        = res_q;
  assign CarryOut         = cout_q;
  assign Resultado_valido = valido_q;
  assign Enter_pulso      = enter_pulso;
endmodule

// File: tb/tb_sequenciador_rpn.sv
// Bench for sequenciador_rpn: one instance wrapping at the result step, one chaining the result into A,
// both driven by the same buttons, switches and ALU inputs.

module tb_sequenciador_rpn;
  localparam int W  = 8;
  localparam int DB = 16;

  logic         Clock = 1'b0;
  logic         Reset_n;
  logic         Enter;
  logic         Limpar;
  logic [W-1:0] Chaves;
  logic [W-1:0] Resultado_ula;
  logic         Carry_ula;

  logic [W-1:0] a_0, b_0, r_0, a_1, b_1, r_1;
  logic [2:0]   op_0, op_1;
  logic [1:0]   passo_0, passo_1;
  logic         ci_0, co_0, v_0, p_0, ci_1, co_1, v_1, p_1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [31:0] exp_q[$];

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  sequenciador_rpn #(.LARGURA(W), .DEBOUNCE_CICLOS(DB), .ENCADEAR(0)) dut0 (
    .Clock(Clock), .Reset_n(Reset_n), .Enter(Enter), .Limpar(Limpar), .Chaves(Chaves),
    .Resultado_ula(Resultado_ula), .Carry_ula(Carry_ula),
    .OperandoA(a_0), .OperandoB(b_0), .Operacao(op_0), .CarryIn(ci_0), .Passo(passo_0),
    .Resultado(r_0), .CarryOut(co_0), .Resultado_valido(v_0), .Enter_pulso(p_0)
  );

  sequenciador_rpn #(.LARGURA(W), .DEBOUNCE_CICLOS(DB), .ENCADEAR(1)) dut1 (
    .Clock(Clock), .Reset_n(Reset_n), .Enter(Enter), .Limpar(Limpar), .Chaves(Chaves),
    .Resultado_ula(Resultado_ula), .Carry_ula(Carry_ula),
    .OperandoA(a_1), .OperandoB(b_1), .Operacao(op_1), .CarryIn(ci_1), .Passo(passo_1),
    .Resultado(r_1), .CarryOut(co_1), .Resultado_valido(v_1), .Enter_pulso(p_1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse scoreboard: each expected pulse is the cycle stamp at which the strobe must be seen.
  always @(negedge Clock) begin
    if (p_0 || p_1) check("pulse_pair", {31'b0, p_1}, {31'b0, p_0});
    if (p_0) begin
      if (exp_q.size() > 0) check("pulse_at", cyc, exp_q.pop_front());
      else check("pulse_unexp", cyc, 32'h0);
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic chk0(input string t, input logic [W-1:0] a, b, input logic [2:0] op,
                      input logic ci, input logic [1:0] ps, input logic [W-1:0] r,
                      input logic co, v);
    check({t, "_0_a"}, a_0, a);     check({t, "_0_b"}, b_0, b);
    check({t, "_0_op"}, op_0, op);  check({t, "_0_ci"}, ci_0, ci);
    check({t, "_0_passo"}, passo_0, ps);
    check({t, "_0_res"}, r_0, r);   check({t, "_0_co"}, co_0, co);
    check({t, "_0_val"}, v_0, v);
  endtask

  task automatic chk1(input string t, input logic [W-1:0] a, b, input logic [2:0] op,
                      input logic ci, input logic [1:0] ps, input logic [W-1:0] r,
                      input logic co, v);
    check({t, "_1_a"}, a_1, a);     check({t, "_1_b"}, b_1, b);
    check({t, "_1_op"}, op_1, op);  check({t, "_1_ci"}, ci_1, ci);
    check({t, "_1_passo"}, passo_1, ps);
    check({t, "_1_res"}, r_1, r);   check({t, "_1_co"}, co_1, co);
    check({t, "_1_val"}, v_1, v);
  endtask

  // Clean Enter press: raw first sampled at the next edge, strobe seen DB+2 stamps after driving.
  task automatic press(input logic [W-1:0] sw);
    Chaves = sw;
    Enter  = 1'b1;
    exp_q.push_back(cyc + DB + 2);
    ticks(25);
    Enter = 1'b0;
    ticks(25);
  endtask

  initial begin
    Reset_n       = 1'b0;
    Enter         = 1'b1;
    Limpar        = 1'b0;
    Chaves        = 8'h25;
    Resultado_ula = 8'h00;
    Carry_ula     = 1'b0;
    ticks(3);
    chk0("reset", 8'h00, 8'h00, 3'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    chk1("reset", 8'h00, 8'h00, 3'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    check("reset_pulse", {31'b0, p_0}, 32'h0);

    // Enter held through reset release gives one strobe -> operand A.
    Reset_n = 1'b1;
    exp_q.push_back(cyc + DB + 2);
    ticks(25);
    Enter = 1'b0;
    ticks(25);
    chk0("stepA", 8'h25, 8'h00, 3'd0, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0);
    chk1("stepA", 8'h25, 8'h00, 3'd0, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0);

    // Bouncing Enter, then a steady press -> operand B.
    Chaves = 8'h1A;
    for (int i = 0; i < 6; i++) begin
      Enter = 1'b1; ticks(5);
      Enter = 1'b0; ticks(5);
    end
    press(8'h1A);
    chk0("stepB", 8'h25, 8'h1A, 3'd0, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0);

    // 10-cycle glitch is rejected.
    Chaves = 8'hFF;
    Enter = 1'b1; ticks(10);
    Enter = 1'b0; ticks(30);
    check("glitch_passo", passo_0, 2'd2);
    check("glitch_b", b_0, 8'h1A);

    press(8'h08);
    chk0("stepOp", 8'h25, 8'h1A, 3'd0, 1'b1, 2'd3, 8'h00, 1'b0, 1'b0);

    Resultado_ula = 8'h40;
    Carry_ula     = 1'b0;
    press(8'h77);
    chk0("res1", 8'h25, 8'h1A, 3'd0, 1'b1, 2'd0, 8'h40, 1'b0, 1'b1);
    chk1("res1", 8'h40, 8'h1A, 3'd0, 1'b1, 2'd1, 8'h40, 1'b0, 1'b1);

    // Chained sequence on dut1; dut0 restarts at A with the same switches.
    press(8'h02);
    press(8'h0B);
    chk1("chainOp", 8'h40, 8'h02, 3'd3, 1'b1, 2'd3, 8'h40, 1'b0, 1'b1);
    Resultado_ula = 8'h42;
    Carry_ula     = 1'b1;
    press(8'h05);
    chk0("dut0Op", 8'h02, 8'h0B, 3'd5, 1'b0, 2'd3, 8'h40, 1'b0, 1'b1);
    chk1("res2", 8'h42, 8'h02, 3'd3, 1'b1, 2'd1, 8'h42, 1'b1, 1'b1);
    press(8'h11);
    chk0("res2", 8'h02, 8'h0B, 3'd5, 1'b0, 2'd0, 8'h42, 1'b1, 1'b1);
    chk1("stepB2", 8'h42, 8'h11, 3'd3, 1'b1, 2'd2, 8'h42, 1'b1, 1'b1);

    // Limpar with dut1 at step 10.
    Limpar = 1'b1; ticks(25);
    Limpar = 1'b0; ticks(25);
    chk0("clr", 8'h00, 8'h00, 3'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    chk1("clr", 8'h00, 8'h00, 3'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);

    // Limpar and Enter edges on the same cycle: Limpar wins, Enter strobe still visible.
    Chaves = 8'h33;
    Limpar = 1'b1;
    Enter  = 1'b1;
    exp_q.push_back(cyc + DB + 2);
    ticks(25);
    Limpar = 1'b0;
    Enter  = 1'b0;
    ticks(25);
    check("both_passo", passo_0, 2'd0);
    check("both_a", a_0, 8'h00);
    check("both_passo1", passo_1, 2'd0);

    // Reset at step 11 with the Enter debounce counter part-way.
    press(8'h12);
    press(8'h34);
    press(8'h0E);
    check("pre_rst_passo", passo_0, 2'd3);
    check("pre_rst_op", op_0, 3'd6);
    Enter = 1'b1;
    ticks(10);
    Reset_n = 1'b0;
    ticks(2);
    Enter = 1'b0;
    ticks(1);
    Reset_n = 1'b1;
    ticks(40);
    chk0("midrst", 8'h00, 8'h00, 3'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    chk1("midrst", 8'h00, 8'h00, 3'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);

    check("pulse_missing", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
